// File: rtl/pipe_hold_ctrl_if.sv
// pipe_hold_ctrl_if: request/response bundle between the core pipeline and
// the hold/flush controller.
//   master : pipeline side, drives the stall/jump/interrupt requests and
//            consumes hold_flag, PC redirect and CSR write strobes.
//   slave  : the controller (pipe_hold_ctrl).
interface pipe_hold_ctrl_if;
  // requests
  logic        mem_busy;
  logic        jump_req;
  logic [31:0] jump_addr;
  logic        load_use;
  logic        int_req;
  logic        int_en;
  logic [31:0] mtvec;
  logic        ex_valid;
  logic [31:0] ex_inst_addr;
  logic [31:0] id_inst_addr;
  // responses
  logic [2:0]  hold_flag;
  logic        pc_wr;
  logic [31:0] pc_wr_addr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        int_ack;

  modport master (
    output mem_busy, jump_req, jump_addr, load_use, int_req, int_en, mtvec,
           ex_valid, ex_inst_addr, id_inst_addr,
    input  hold_flag, pc_wr, pc_wr_addr, csr_we, csr_waddr, csr_wdata, int_ack
  );

  modport slave (
    input  mem_busy, jump_req, jump_addr, load_use, int_req, int_en, mtvec,
           ex_valid, ex_inst_addr, id_inst_addr,
    output hold_flag, pc_wr, pc_wr_addr, csr_we, csr_waddr, csr_wdata, int_ack
  );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// pipe_hold_ctrl: pipeline hold/flush arbiter and interrupt-entry sequencer.
// Turns bus stall, EX jump, load-use and external interrupt requests into the
// single hold_flag code (0 NONE, 3 ID, 4 EX, 5 PPL), issues PC redirects and,
// on interrupt entry, writes mepc then mcause before redirecting to mtvec.
// Ports:
//   clk  - core clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - pipe_hold_ctrl_if.slave (requests in, hold/redirect/CSR out)
// All responses are combinational from state and current requests so the
// pipeline registers are steered in the same cycle.
// Build option: define PIPE_HOLD_INT_EN to include the interrupt FSM, epc
// register and CSR write outputs; otherwise only the stall/jump/load-use
// arbitration exists and the interrupt/CSR outputs are tied to 0.
module pipe_hold_ctrl #(
  parameter logic [31:0] MTVEC_DEFAULT = 32'h0000_0100,
  parameter logic [31:0] MCAUSE_EXT    = 32'h8000_000B
) (
  input logic             clk,
  input logic             rst,
  pipe_hold_ctrl_if.slave bus
);
  localparam logic [2:0]  HOLD_NONE = 3'd0;
  localparam logic [2:0]  HOLD_ID   = 3'd3;
  localparam logic [2:0]  HOLD_EX   = 3'd4;
  localparam logic [2:0]  HOLD_PPL  = 3'd5;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  logic        int_take;
  logic [2:0]  idle_hold;
  logic        idle_pc_wr;
  logic [2:0]  hold_flag;
  logic        pc_wr;
  logic [31:0] pc_wr_addr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        int_ack;

  // IDLE arbitration. An accepted interrupt freezes everything and swallows
  // a same-cycle jump (its target becomes mepc instead of a redirect).
  always_comb begin
    idle_hold  = HOLD_NONE;
    idle_pc_wr = 1'b0;
    if (bus.mem_busy || int_take) begin
      idle_hold = HOLD_PPL;
    end else if (bus.jump_req) begin
      idle_hold  = HOLD_EX;
      idle_pc_wr = 1'b1;
    end else if (bus.load_use) begin
      idle_hold = HOLD_ID;
    end
  end

`ifdef PIPE_HOLD_INT_EN
  typedef enum logic [1:0] {S_IDLE, S_MEPC, S_MCAUSE, S_JUMP} state_t;

  state_t      state;
  logic [31:0] epc;
  logic [31:0] trap_vec;
  logic        unused_bits;

  assign int_take    = (state == S_IDLE) & bus.int_req & bus.int_en & ~bus.mem_busy;
  assign trap_vec    = (bus.mtvec == '0) ? MTVEC_DEFAULT : {bus.mtvec[31:2], 2'b00};
  assign unused_bits = ^bus.mtvec[1:0];

  // Once entered, the save sequence runs to completion regardless of the
  // request lines; only reset aborts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      epc   <= '0;
    end else begin
      case (state)
        S_IDLE: if (int_take) begin
          state <= S_MEPC;
          // Resume point: pending jump target, else the oldest real
          // instruction still in the pipe.
          epc   <= bus.jump_req ? bus.jump_addr :
                   bus.ex_valid ? bus.ex_inst_addr : bus.id_inst_addr;
        end
        S_MEPC:   state <= S_MCAUSE;
        S_MCAUSE: state <= S_JUMP;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    hold_flag  = HOLD_NONE;
    pc_wr      = 1'b0;
    pc_wr_addr = '0;
    csr_we     = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    int_ack    = 1'b0;
    case (state)
      S_IDLE: begin
        hold_flag  = idle_hold;
        pc_wr      = idle_pc_wr;
        pc_wr_addr = idle_pc_wr ? bus.jump_addr : '0;
      end
      S_MEPC: begin
        hold_flag = HOLD_PPL;
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = epc;
      end
      S_MCAUSE: begin
        hold_flag = HOLD_PPL;
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = MCAUSE_EXT;
      end
      default: begin
        hold_flag  = HOLD_EX;
        pc_wr      = 1'b1;
        pc_wr_addr = trap_vec;
        int_ack    = 1'b1;
      end
    endcase
  end
`else
  logic unused_ins;

  assign int_take   = 1'b0;
  assign unused_ins = ^{clk, rst, bus.int_req, bus.int_en, bus.mtvec, bus.ex_valid,
                        bus.ex_inst_addr, bus.id_inst_addr, MTVEC_DEFAULT, MCAUSE_EXT,
                        CSR_MEPC, CSR_MCAUSE};

  always_comb begin
    hold_flag  = idle_hold;
    pc_wr      = idle_pc_wr;
    pc_wr_addr = idle_pc_wr ? bus.jump_addr : '0;
    csr_we     = 1'b0;
    csr_waddr  = '0;
    csr_wdata  = '0;
    int_ack    = 1'b0;
  end
`endif

  assign bus.hold_flag  = hold_flag;
  assign bus.pc_wr      = pc_wr;
  assign bus.pc_wr_addr = pc_wr_addr;
  assign bus.csr_we     = csr_we;
  assign bus.csr_waddr  = csr_waddr;
  assign bus.csr_wdata  = csr_wdata;
  assign bus.int_ack    = int_ack;
endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: vector table for IDLE arbitration, hand-written
// interrupt / reset sequences, then randomized traffic against a model that
// represents interrupt entry as a queue of scripted future cycles.
module tb_pipe_hold_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hold_ctrl_if bus();
  pipe_hold_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef PIPE_HOLD_INT_EN
  localparam bit INT_ON = 1'b1;
`else
  localparam bit INT_ON = 1'b0;
`endif

  typedef struct packed {
    logic        mem_busy;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        load_use;
    logic        int_req;
    logic        int_en;
    logic [31:0] mtvec;
    logic        ex_valid;
    logic [31:0] ex_inst_addr;
    logic [31:0] id_inst_addr;
  } in_t;

  typedef struct packed {
    logic [2:0]  hold;
    logic        pc_wr;
    logic [31:0] pc_wr_addr;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        int_ack;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  // pending scripted cycles after an accepted interrupt: 0 mepc, 1 mcause, 2 redirect
  typedef struct {
    int          kind;
    logic [31:0] epc;
  } pend_t;

  pend_t pq[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic in_t rq(bit mb, bit jr, logic [31:0] ja, bit lu, bit ir, bit ie,
                             logic [31:0] mtv, bit exv, logic [31:0] exa, logic [31:0] ida);
    in_t v;
    v.mem_busy = mb; v.jump_req = jr; v.jump_addr = ja; v.load_use = lu;
    v.int_req = ir; v.int_en = ie; v.mtvec = mtv; v.ex_valid = exv;
    v.ex_inst_addr = exa; v.id_inst_addr = ida;
    return v;
  endfunction

  function automatic out_t o(logic [2:0] h, bit pw, logic [31:0] pa, bit we,
                             logic [11:0] wa, logic [31:0] wd, bit ack);
    out_t r;
    r.hold = h; r.pc_wr = pw; r.pc_wr_addr = pa; r.csr_we = we;
    r.csr_waddr = wa; r.csr_wdata = wd; r.int_ack = ack;
    return r;
  endfunction

  task automatic drive(input in_t v);
    bus.mem_busy = v.mem_busy; bus.jump_req = v.jump_req; bus.jump_addr = v.jump_addr;
    bus.load_use = v.load_use; bus.int_req = v.int_req; bus.int_en = v.int_en;
    bus.mtvec = v.mtvec; bus.ex_valid = v.ex_valid; bus.ex_inst_addr = v.ex_inst_addr;
    bus.id_inst_addr = v.id_inst_addr;
  endtask

  task automatic chk(input string nm, input out_t exp);
    out_t act;
    act = o(bus.hold_flag, bus.pc_wr, bus.pc_wr_addr, bus.csr_we, bus.csr_waddr,
            bus.csr_wdata, bus.int_ack);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got hold=%0d pc_wr=%b pc_addr=%h csr_we=%b waddr=%h wdata=%h ack=%b ; want hold=%0d pc_wr=%b pc_addr=%h csr_we=%b waddr=%h wdata=%h ack=%b",
                  nm, act.hold, act.pc_wr, act.pc_wr_addr, act.csr_we, act.csr_waddr,
                  act.csr_wdata, act.int_ack, exp.hold, exp.pc_wr, exp.pc_wr_addr,
                  exp.csr_we, exp.csr_waddr, exp.csr_wdata, exp.int_ack);
  endtask

  // Reference: either replay the next scripted interrupt cycle or apply the
  // priority rules of the idle controller.
  task automatic model_step(input in_t v, output out_t e);
    pend_t p;
    bit take;
    logic [31:0] ep;
    e = '0;
    if (pq.size() > 0) begin
      p = pq.pop_front();
      case (p.kind)
        0: e = o(3'd5, 0, 0, 1, 12'h341, p.epc, 0);
        1: e = o(3'd5, 0, 0, 1, 12'h342, 32'h8000_000B, 0);
        default: e = o(3'd4, 1, (v.mtvec == 0) ? 32'h100 : (v.mtvec & ~32'h3), 0, 0, 0, 1);
      endcase
    end else begin
      take = INT_ON && v.int_req && v.int_en && !v.mem_busy;
      if (v.mem_busy || take) e.hold = 3'd5;
      else if (v.jump_req) begin e.hold = 3'd4; e.pc_wr = 1; e.pc_wr_addr = v.jump_addr; end
      else if (v.load_use) e.hold = 3'd3;
      if (take) begin
        ep = v.jump_req ? v.jump_addr : v.ex_valid ? v.ex_inst_addr : v.id_inst_addr;
        pq.push_back('{0, ep});
        pq.push_back('{1, 32'h0});
        pq.push_back('{2, 32'h0});
      end
    end
  endtask

  // one clock cycle: drive after the edge, check before the next edge
  task automatic cyc(input in_t v, input string nm, input bit use_exp, input out_t hexp);
    out_t e;
    @(posedge clk); #1;
    drive(v);
    #3;
    model_step(v, e);
    if (use_exp) chk(nm, hexp);
    chk({nm, "_model"}, e);
  endtask

  vec_t tbl[8];
  in_t  z;

  initial begin
    z = '0;
    drive(z);
    #2;
    chk("reset_outputs", '0);

    tbl[0] = '{rq(0,0,0,0,0,0,0,0,0,0),               o(0,0,0,0,0,0,0)};
    tbl[1] = '{rq(0,1,32'h40,1,0,0,0,0,0,0),          o(4,1,32'h40,0,0,0,0)};
    tbl[2] = '{rq(0,0,0,1,0,0,0,0,0,0),               o(3,0,0,0,0,0,0)};
    tbl[3] = '{rq(1,1,32'h40,0,0,0,0,0,0,0),          o(5,0,0,0,0,0,0)};
    tbl[4] = '{rq(0,1,32'hDEAD_BEE0,0,0,0,0,0,0,0),   o(4,1,32'hDEAD_BEE0,0,0,0,0)};
    tbl[5] = '{rq(1,0,0,1,0,0,0,0,0,0),               o(5,0,0,0,0,0,0)};
    tbl[6] = '{rq(0,0,0,1,1,0,32'h200,1,32'h1C,0),    o(3,0,0,0,0,0,0)};
    tbl[7] = '{rq(0,0,0,0,0,1,0,0,0,0),               o(0,0,0,0,0,0,0)};

    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(z, "idle_after_reset", 1, o(0,0,0,0,0,0,0));
    for (int i = 0; i < 8; i++) cyc(tbl[i].in, $sformatf("vec%0d", i), 1, tbl[i].exp);

    // interrupt with EX valid, mtvec aligned
    cyc(rq(0,0,0,0,1,1,32'h200,1,32'h1C,32'h18), "int1_take", 1, o(INT_ON ? 5 : 0,0,0,0,0,0,0));
    cyc(rq(0,0,0,0,1,1,32'h200,1,32'h1C,32'h18), "int1_mepc", 1,
        INT_ON ? o(5,0,0,1,12'h341,32'h1C,0) : o(0,0,0,0,0,0,0));
    cyc(rq(0,0,0,0,1,1,32'h200,1,32'h1C,32'h18), "int1_mcause", 1,
        INT_ON ? o(5,0,0,1,12'h342,32'h8000_000B,0) : o(0,0,0,0,0,0,0));
    cyc(rq(0,0,0,0,0,1,32'h200,0,0,0), "int1_jump", 1,
        INT_ON ? o(4,1,32'h200,0,0,0,1) : o(0,0,0,0,0,0,0));
    cyc(z, "int1_after", 1, o(0,0,0,0,0,0,0));

    // interrupt beats a jump; mtvec=0; int_req dropped and busy/load_use ignored mid-sequence
    cyc(rq(0,1,32'h80,0,1,1,0,1,32'h1C,0), "int2_take", 1,
        INT_ON ? o(5,0,0,0,0,0,0) : o(4,1,32'h80,0,0,0,0));
    cyc(rq(0,0,0,0,1,1,0,0,0,0), "int2_mepc", 1,
        INT_ON ? o(5,0,0,1,12'h341,32'h80,0) : o(0,0,0,0,0,0,0));
    cyc(rq(1,0,0,0,0,1,0,0,0,0), "int2_mcause", 1,
        INT_ON ? o(5,0,0,1,12'h342,32'h8000_000B,0) : o(5,0,0,0,0,0,0));
    cyc(rq(0,0,0,1,0,1,0,0,0,0), "int2_jump", 1,
        INT_ON ? o(4,1,32'h100,0,0,0,1) : o(3,0,0,0,0,0,0));
    cyc(z, "int2_after", 1, o(0,0,0,0,0,0,0));

    // mem_busy blocks interrupt acceptance
    cyc(rq(1,0,0,0,1,1,32'h300,1,32'h44,0), "int_busy", 1, o(5,0,0,0,0,0,0));
    cyc(z, "int_busy_after", 1, o(0,0,0,0,0,0,0));

    // reset mid-sequence, during MCAUSE
    cyc(rq(0,0,0,0,1,1,32'h400,1,32'h24,0), "rst_take", 1, o(INT_ON ? 5 : 0,0,0,0,0,0,0));
    cyc(rq(0,0,0,0,0,1,32'h400,0,0,0), "rst_mepc", 1,
        INT_ON ? o(5,0,0,1,12'h341,32'h24,0) : o(0,0,0,0,0,0,0));
    cyc(z, "rst_mcause", 1, INT_ON ? o(5,0,0,1,12'h342,32'h8000_000B,0) : o(0,0,0,0,0,0,0));
    rst = 1'b1;
    pq.delete();
    #1;
    chk("rst_async", o(0,0,0,0,0,0,0));
    @(posedge clk); #2;
    rst = 1'b0;
    #2;
    chk("rst_released", o(0,0,0,0,0,0,0));
    cyc(z, "rst_no_ack", 1, o(0,0,0,0,0,0,0));
    cyc(rq(0,1,32'h64,1,0,0,0,0,0,0), "rst_idle_jump", 1, o(4,1,32'h64,0,0,0,0));

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_t v;
      v.mem_busy     = ($urandom_range(0, 5) == 0);
      v.jump_req     = ($urandom_range(0, 2) == 0);
      v.jump_addr    = $urandom & ~32'h3;
      v.load_use     = ($urandom_range(0, 2) == 0);
      v.int_req      = ($urandom_range(0, 7) == 0);
      v.int_en       = $urandom_range(0, 1);
      v.mtvec        = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      v.ex_valid     = $urandom_range(0, 1);
      v.ex_inst_addr = $urandom & ~32'h3;
      v.id_inst_addr = $urandom & ~32'h3;
      cyc(v, $sformatf("rand%0d", i), 0, '0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Pipeline hold/flush controller and interrupt-entry sequencer for the 5-stage interrupt-capable core. Arbitrates stall and flush requests (bus stall, EX-resolved jumps, load-use hazards, external interrupts) into the single `hold_flag` code consumed by the PC, IF/ID and ID/EX pipeline registers. Drives PC redirects and runs the multi-cycle CSR save sequence (mepc, mcause) on interrupt entry.

## Interface
- `MTVEC_DEFAULT`, 32'h0000_0100: trap vector used while `mtvec` reads zero.
- `MCAUSE_EXT`, 32'h8000_000B: mcause value written for an external interrupt.
- `clk` input 1: core clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mem_busy` input 1: data bus not ready; the whole pipeline must freeze.
- `jump_req` input 1: EX resolved a taken branch/jump this cycle.
- `jump_addr` input 32: target of `jump_req`.
- `load_use` input 1: ID instruction depends on a load currently in EX.
- `int_req` input 1: level external interrupt request.
- `int_en` input 1: mstatus.MIE.
- `mtvec` input 32: current mtvec CSR value.
- `ex_valid` input 1: ID/EX holds a real instruction (not a bubble).
- `ex_inst_addr` input 32: PC of the instruction in EX.
- `id_inst_addr` input 32: PC of the instruction in ID.
- `hold_flag` output 3: 0 NONE, 1 PC (hold PC), 2 IF (hold PC+IF/ID), 3 ID (hold PC+IF/ID, bubble ID/EX), 4 EX (bubble IF/ID and ID/EX), 5 PPL (freeze PC, bubble IF/ID and ID/EX).
- `pc_wr` output 1: one-cycle PC redirect strobe.
- `pc_wr_addr` output 32: redirect target.
- `csr_we` output 1: CSR write strobe.
- `csr_waddr` output 12: 12'h341 (mepc) or 12'h342 (mcause).
- `csr_wdata` output 32: CSR write data.
- `int_ack` output 1: one-cycle pulse when the trap redirect issues.

## Operation
- States: IDLE, MEPC, MCAUSE, JUMP (2-bit `state`, plus 32-bit `epc` register).
- IDLE: `hold_flag` priority: `mem_busy` -> PPL; else `jump_req` -> EX with `pc_wr=1`, `pc_wr_addr=jump_addr`; else `load_use` -> ID; else NONE.
- IDLE -> MEPC when `int_req & int_en & ~mem_busy`. The interrupt wins over `jump_req` and `load_use` in that cycle: `hold_flag=PPL`, no `pc_wr`. `epc` captures `jump_req ? jump_addr : ex_valid ? ex_inst_addr : id_inst_addr`.
- MEPC: `hold_flag=PPL`, `csr_we=1`, `csr_waddr=12'h341`, `csr_wdata=epc`. Always goes to MCAUSE.
- MCAUSE: `hold_flag=PPL`, `csr_we=1`, `csr_waddr=12'h342`, `csr_wdata=MCAUSE_EXT`. Always goes to JUMP.
- JUMP: `hold_flag=EX`, `pc_wr=1`, `pc_wr_addr = (mtvec==0) ? MTVEC_DEFAULT : {mtvec[31:2],2'b00}`, `int_ack=1`. Always returns to IDLE.
- In non-IDLE states, `jump_req`, `load_use` and `mem_busy` are ignored. The pipeline is already frozen, so `mem_busy` cannot assert from new accesses.
- Deassertion of `int_req` after leaving IDLE does not abort the sequence.
- Outputs not listed for a state are 0.

## Timing
- All `hold_flag`, `pc_wr*` and `csr_*` outputs are combinational from `state` and the current inputs, giving same-cycle control of the pipeline registers.
- `state` and `epc` are registered.
- Interrupt entry latency: 4 cycles (IDLE-detect, MEPC, MCAUSE, JUMP). The trap-vector fetch occurs in the cycle after JUMP.
- `int_ack` and `pc_wr` in JUMP are exactly one cycle wide.
- Back-to-back interrupt: in the cycle after JUMP, IDLE re-evaluates. Software is expected to have MIE cleared by CSR hardware on mepc write; the block itself does not mask.
- Reset (asynchronous, any time, including mid-sequence): `state=IDLE`, `epc=0`. Outputs immediately become those of IDLE with the current inputs. With all request inputs 0: `hold_flag=0`, `pc_wr=0`, `pc_wr_addr=0`, `csr_we=0`, `csr_waddr=0`, `csr_wdata=0`, `int_ack=0`.

## Configuration
- `PIPE_HOLD_INT_EN` defined: interrupt FSM, `epc` register and CSR outputs are present as above.
- `PIPE_HOLD_INT_EN` undefined:
  - State fixed at IDLE; `int_req`/`int_en` are ignored.
  - `csr_we`, `csr_waddr`, `csr_wdata` and `int_ack` are tied to 0.
  - Only the stall/jump/load-use arbitration remains.

## Test plan
- Reset release with all inputs 0 -> `hold_flag=0`, `pc_wr=0`, `csr_we=0` every cycle.
- `load_use=1` and `jump_req=1`, `jump_addr=32'h40` in the same cycle -> `hold_flag=4`, `pc_wr=1`, `pc_wr_addr=32'h40`. Then `load_use` alone -> `hold_flag=3`.
- `mem_busy=1` with `jump_req=1` -> `hold_flag=5`, `pc_wr=0`.
- `int_req=int_en=1`, `ex_valid=1`, `ex_inst_addr=32'h1C`, `mtvec=32'h200` -> `hold_flag` sequence 5,5,5,4. Writes mepc=32'h1C, then mcause=32'h8000_000B. Then `pc_wr` with `pc_wr_addr=32'h200` and `int_ack=1`, then `hold_flag=0`.
- Interrupt with `jump_req=1`, `jump_addr=32'h80`, `mtvec=0` -> mepc=32'h80 and redirect to 32'h100. `int_req` dropped during MCAUSE still completes.
- `rst` pulsed during MCAUSE -> `csr_we=0` immediately; no `int_ack`; IDLE behaviour resumes after release.
